button_event_gen: RTL and testbench

BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

---
 rtl/button_event_gen.sv | 107 ++++++++++
 tb/tb_button_event_gen.sv | 108 ++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// button_event_gen: press/release/click/long-press/auto-repeat pulse generator for a debounced button.
// Define BTN_AUTO_REPEAT_EN to enable repeatPulse while a long press is held.
module button_event_gen #(
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic pButtonState,
  output logic pressPulse,
  output logic releasePulse,
  output logic clickPulse,
  output logic longPulse,
  output logic repeatPulse,
  output logic held
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DOWN = 2'd1;
  localparam logic [1:0] LONG = 2'd2;
  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("HOLD_CYCLES and REPEAT_CYCLES must both be at least 2");
  end
  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        click_q, click_d;
  logic        long_q, long_d;
  logic        repeat_q, repeat_d;
  logic        held_q, held_d;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    held_d    = state_q == LONG;
    case (state_q)
      IDLE: begin
        if (pButtonState) begin
          state_d = DOWN;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      DOWN: begin
        if (!pButtonState) begin
          state_d   = IDLE;
          release_d = 1'b1;
          click_d   = 1'b1;
        end else if (cnt_q == 32'(HOLD_CYCLES - 1)) begin
          state_d = LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      LONG: begin
        if (!pButtonState) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          repeat_d = cnt_q == 32'(REPEAT_CYCLES - 1);
          cnt_d    = repeat_d ? '0 : cnt_q + 32'd1;
`else
          cnt_d = cnt_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end
  assign pressPulse   = press_q;
  assign releasePulse = release_q;
  assign clickPulse   = click_q;
  assign longPulse    = long_q;
  assign repeatPulse  = repeat_q;
  assign held         = held_q;
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: vector table plus scoreboard queue for button_event_gen with HOLD=8, REPEAT=4.
module tb_button_event_gen;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic pButtonState = 1'b0;
  logic pressPulse, releasePulse, clickPulse, longPulse, repeatPulse, held;
  int total = 0;
  int bad = 0;
  logic [5:0] exp_q[$];
  // Output vector order: {press, release, click, long, repeat, held}
  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] P  = 6'b100000;
  localparam logic [5:0] RC = 6'b011000;
  localparam logic [5:0] L  = 6'b000100;
  localparam logic [5:0] RH = 6'b010001;
  localparam int NV = 18;
  typedef struct packed {
    logic       b;
    logic [5:0] e;
  } vec_t;
  vec_t tbl [NV];
  button_event_gen #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET), .pButtonState(pButtonState),
    .pressPulse(pressPulse), .releasePulse(releasePulse), .clickPulse(clickPulse),
    .longPulse(longPulse), .repeatPulse(repeatPulse), .held(held)
  );
  always #5 CLK = ~CLK;
  task automatic compare(input string name);
    logic [5:0] got, want;
    got = {pressPulse, releasePulse, clickPulse, longPulse, repeatPulse, held};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b at %0t", name, got, want, $time);
    end
  endtask
  task automatic step(input logic b, input logic [5:0] e, input string name);
    exp_q.push_back(e);
    pButtonState = b;
    @(posedge CLK);
    #1;
    compare(name);
  endtask
  task automatic check_now(input logic [5:0] e, input string name);
    exp_q.push_back(e);
    compare(name);
  endtask
  initial begin
    logic [5:0] e;
    tbl[0]  = '{1'b1, P};
    tbl[1]  = '{1'b1, Z};
    tbl[2]  = '{1'b1, Z};
    tbl[3]  = '{1'b0, RC};
    tbl[4]  = '{1'b0, Z};
    tbl[5]  = '{1'b1, P};
    tbl[6]  = '{1'b0, RC};
    tbl[7]  = '{1'b0, Z};
    tbl[8]  = '{1'b1, P};
    for (int i = 9; i < 16; i++) tbl[i] = '{1'b1, Z};
    tbl[16] = '{1'b0, RC};
    tbl[17] = '{1'b0, Z};
    #1;
    check_now(Z, "reset_async");
    repeat (3) @(posedge CLK);
    #1;
    check_now(Z, "reset_held");
    @(negedge CLK);
    RESET = 1'b0;
    step(1'b0, Z, "idle");
    step(1'b0, Z, "idle2");
    for (int i = 0; i < NV; i++) step(tbl[i].b, tbl[i].e, $sformatf("vec%0d", i));
    for (int k = 0; k < 22; k++) begin
      e = Z;
      if (k == 0) e = P;
      if (k == 8) e = L;
      if (k >= 9 && k <= 20) e[0] = 1'b1;
      if (k == 20) e[4] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
      if (k == 12 || k == 16) e[1] = 1'b1;
`endif
      step(k < 20, e, $sformatf("hold20_k%0d", k));
    end
    step(1'b1, P, "rel9_press");
    for (int k = 1; k < 8; k++) step(1'b1, Z, $sformatf("rel9_k%0d", k));
    step(1'b1, L, "rel9_long");
    step(1'b0, RH, "rel9_release");
    step(1'b0, Z, "rel9_after");
    step(1'b1, P, "rst_press");
    for (int k = 1; k < 5; k++) step(1'b1, Z, $sformatf("rst_k%0d", k));
    #2;
    RESET = 1'b1;
    #1;
    check_now(Z, "rst_mid_async");
    @(posedge CLK);
    #1;
    check_now(Z, "rst_mid_edge");
    @(negedge CLK);
    RESET = 1'b0;
    step(1'b1, P, "rst_repress");
    for (int k = 1; k < 8; k++) step(1'b1, Z, $sformatf("rst2_k%0d", k));
    step(1'b1, L, "rst2_long");
    step(1'b0, RH, "rst2_release");
    step(1'b0, Z, "rst2_after");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
